if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID consumer (decode / register-file read).
- Owns the architectural `program_counter`; drives the instruction-memory address; latches the fetched instruction and PC+4 into the IF/ID pipeline register.
- Honours load-use stalls, and branch/jump redirects and flushes from later stages.
- Start address comes from the top-level PC value input; PC is reloaded on reset.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address
- INSTR_W, 32, instruction width
- NOP_INSTR, 32'h0000_0000, bubble word loaded into IF/ID on reset/flush/redirect (MIPS sll $0,$0,0)

Ports:
- clk  in  1  pipeline clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- start_pc  in  ADDR_W  PC loaded on reset; bits [1:0] ignored (forced 0)
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  squash the instruction being latched into IF/ID
- redirect_valid  in  1  branch/jump taken, load redirect_pc
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced 0
- imem_addr  out  ADDR_W  instruction-memory address, combinational read
- imem_rdata  in  INSTR_W  instruction at imem_addr, valid in the same cycle
- program_counter  out  ADDR_W  current fetch PC
- ifid_instr  out  INSTR_W  IF/ID instruction
- ifid_pc_plus4  out  ADDR_W  IF/ID PC+4 (for branch target / jal link)
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- imem_addr = program_counter (combinational); pc_plus4 = program_counter + 4 modulo 2^ADDR_W.
- Reset (rst=1 at posedge, overrides everything):
  - program_counter <= {start_pc[ADDR_W-1:2],2'b00}
  - ifid_instr <= NOP_INSTR, ifid_pc_plus4 <= 0, ifid_valid <= 0.
  - Reset asserted mid-operation discards any pending stall/redirect/flush that cycle.
- Per-edge priority when rst=0: redirect_valid > stall > normal; flush is applied to IF/ID independently.
  - redirect_valid=1: PC <= {redirect_pc[ADDR_W-1:2],2'b00}; IF/ID <= bubble (NOP_INSTR, pc_plus4=0, valid=0). Overrides stall and flush.
  - stall=1, redirect_valid=0: PC holds.
    - flush=0: IF/ID holds all fields.
    - flush=1: IF/ID <= bubble.
  - stall=0, redirect_valid=0: PC <= pc_plus4.
    - flush=0: ifid_instr <= imem_rdata, ifid_pc_plus4 <= pc_plus4, ifid_valid <= 1.
    - flush=1: IF/ID <= bubble.
- Latency: instruction at PC X appears in IF/ID one edge after the cycle X is presented on imem_addr.
- Wrap-around: PC 0xFFFF_FFFC advances to 0x0000_0000; ifid_pc_plus4 = 0 in that case. No fault is signalled.
- No X propagation: all registers are assigned on reset; outputs never X after the first reset edge.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_count [31:0] and stall_count [31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - fetch_count +1 on each edge where IF/ID is loaded with ifid_valid=1.
  - stall_count +1 on each edge with stall=1 and redirect_valid=0 (rst=0).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset with start_pc=500, memory word at 500=0x8C130000, at 504=0x8C140004, hold rst 2 cycles.
   - During reset: program_counter=500, ifid_valid=0.
   - Edge 1 after release: ifid_instr=0x8C130000, ifid_pc_plus4=504, program_counter=504.
   - Edge 2: ifid_instr=0x8C140004, program_counter=508.
2. Stall while PC=508, held 2 cycles: PC stays 508 and IF/ID unchanged both edges; after release, next edge PC=512 and ifid_pc_plus4=512.
3. redirect_valid=1 with redirect_pc=600 at PC=512: next edge PC=600, ifid_valid=0, ifid_instr=0; following edge ifid_pc_plus4=604.
4. stall=1, redirect_valid=1 (redirect_pc=700), flush=1 in the same cycle: PC=700, IF/ID bubble. Separately, stall=1 with flush=1: PC held, ifid_valid=0.
5. redirect_pc=0xFFFF_FFFF (low bits forced 0): PC=0xFFFF_FFFC; next edge PC=0x0000_0000, ifid_pc_plus4=0x0000_0000, ifid_valid=1.
6. rst asserted mid-stream together with redirect_valid=1 and start_pc=0x203: PC=0x200, IF/ID bubble. With IF_PERF_CNT_EN defined, fetch_count=0 and stall_count=0 after the reset edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch/stall counters.
module if_stage #(
  parameter int unsigned           ADDR_W    = 32,
  parameter int unsigned           INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  program_counter,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus4,
  output logic               ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               unused_low_bits;

  // PCs are word aligned; the low two bits of both sources are dropped.
  assign unused_low_bits = ^{start_pc[1:0], redirect_pc[1:0]};

  assign pc_plus4        = pc_q + ADDR_W'(4);
  assign imem_addr       = pc_q;
  assign program_counter = pc_q;
  assign ifid_instr      = instr_q;
  assign ifid_pc_plus4   = pc4_q;
  assign ifid_valid      = valid_q;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      if (flush) begin
        instr_d = NOP_INSTR;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    end else begin
      pc_d = pc_plus4;
      if (flush) begin
        instr_d = NOP_INSTR;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= {start_pc[ADDR_W-1:2], 2'b00};
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_q, stall_q;
  logic        fetch_inc, stall_inc;

  assign fetch_inc   = !redirect_valid && !stall && !flush;
  assign stall_inc   = stall && !redirect_valid;
  assign fetch_count = fetch_q;
  assign stall_count = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (fetch_inc && (fetch_q != 32'hFFFF_FFFF)) fetch_q <= fetch_q + 32'd1;
      if (stall_inc && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule
